thor2025_rat_ckpt: RTL
======================

THOR2025_RAT_CKPT -- requirements
Module: thor2025_rat_ckpt

Interface
REQ-001 SHALL have parameters: NAREG, 64, architectural registers; NPREG, 128, physical registers; NLANE, 3, rename/commit lanes; NRD, 9, read ports; NCHECK, 4, checkpoint slots. AW=$clog2(NAREG), PW=$clog2(NPREG), CW=$clog2(NCHECK).
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- nq  in  1  rename group valid
- wr  in  NLANE  per-lane destination write enable
- wra  in  NLANE x AW  lane destination architectural register
- wrp  in  NLANE x PW  lane new physical register
- rn  in  NRD x AW  lookup architectural register
- rrn  out  NRD x PW  mapped physical register
- vn  out  NRD  mapping valid
- ckpt_req  in  1  snapshot requested with this group
- ckpt_ack  out  1  snapshot taken, combinational
- ckpt_id  out  CW  slot used by the snapshot, combinational
- ckpt_full  out  1  no free slot
- ckpt_rel  in  1  release oldest checkpoint (branch resolved correct)
- restore_v  in  1  mispredict restore
- restore_id  in  CW  checkpoint to restore
- flush  in  1  restore speculative map from committed map
- cmtv  in  NLANE  commit lane valid
- cmta  in  NLANE x AW  committed architectural register
- cmtp  in  NLANE x PW  committed physical register
- freev  out  NLANE  free output valid, registered
- freep  out  NLANE x PW  physical register to return to free list, registered

Function
REQ-003 SHALL hold entry {valid, preg} per architectural register in a speculative map, a committed map, and NCHECK checkpoint maps.
REQ-004 rrn/vn SHALL be combinational from the speculative map state at cycle start; same-cycle renames SHALL NOT be visible.
REQ-005 Architectural register 0 SHALL always read {1, 0}; writes and commits to it SHALL be ignored (freev low).
REQ-006 When nq, for each lane with wr set, spec[wra] SHALL become {1, wrp} next cycle; on equal wra the highest-numbered lane SHALL win.
REQ-007 Checkpoints SHALL form a circular queue (head, tail, count); ckpt_full = (count==NCHECK).
REQ-008 ckpt_req with nq and not full SHALL store the post-rename speculative map into slot head, assert ckpt_ack, drive ckpt_id=head, advance head, increment count; when full, ckpt_ack SHALL be low and nothing stored.
REQ-009 ckpt_rel with count>0 SHALL advance tail and decrement count; with count==0 it SHALL be ignored; ckpt_rel and ckpt_req together SHALL leave count unchanged.
REQ-010 restore_v SHALL load spec from slot restore_id, set head=restore_id, count=(restore_id-tail) mod NCHECK, and suppress that cycle's renames and ckpt_req; restore_id outside the live window SHALL be ignored.
REQ-011 flush SHALL load spec from the committed map including same-cycle commits, set head=tail, count=0; priority flush > restore_v > rename.
REQ-012 Each cmtv lane SHALL write cmt[cmta]=cmtp and, next cycle, drive freev=1, freep=previous mapping; for equal cmta the later lane SHALL free the earlier lane's cmtp and the committed map SHALL take the last lane.
REQ-013 Lanes without cmtv SHALL drive freev=0, freep=0 next cycle.
REQ-014 Commit SHALL proceed during flush, restore_v and ckpt_full.

Reset
REQ-015 Reset SHALL set spec and committed entries to {1, a} (identity), clear checkpoint slots, head=tail=count=0, freev=0, freep=0; ckpt_full=0.
REQ-016 Reset SHALL take priority over all inputs and abort any in-progress restore or flush.

Structure
REQ-017 Package thor2025_rat_pkg SHALL hold default parameters and typedef rat_entry_t {valid, preg}.
REQ-018 Checkpoint pointer/count logic SHALL be sub-module thor2025_rat_ckpt_q.

Verification
REQ-019 After reset, rn=5 -> rrn=5, vn=1; rn=0 -> rrn=0.
REQ-020 nq, wr=3'b011, wra={7,7}, wrp={40,41} -> next cycle rn=7 gives rrn=41; same-cycle read gives 7.
REQ-021 Four ckpt_req -> ids 0..3, ckpt_full=1; fifth -> ckpt_ack=0; ckpt_rel+ckpt_req together -> id 0, count stays 4.
REQ-022 ckpt id1 taken with r3->50, later r3->60; restore_v id1 -> rrn(r3)=50, count=1, same-cycle rename dropped.
REQ-023 cmtv lanes 0,1 both r9 with p70,p71 -> freep={9,70}, cmt[9]=71; flush -> spec r9=71, count=0.

Source files
------------

// File: rtl/thor2025_rat_pkg.sv
// Shared defaults and map entry type for the rename alias table with checkpoints.
package thor2025_rat_pkg;

  localparam int unsigned RAT_NAREG  = 64;
  localparam int unsigned RAT_NPREG  = 128;
  localparam int unsigned RAT_NLANE  = 3;
  localparam int unsigned RAT_NRD    = 9;
  localparam int unsigned RAT_NCHECK = 4;
  localparam int unsigned RAT_PW     = $clog2(RAT_NPREG);

  typedef struct packed {
    logic              valid;
    logic [RAT_PW-1:0] preg;
  } rat_entry_t;

endpackage

// File: rtl/thor2025_rat_ckpt_q.sv
// Circular head/tail/count bookkeeping for checkpoint slots, including restore and flush rewinds.
module thor2025_rat_ckpt_q
  import thor2025_rat_pkg::*;
#(
  parameter int unsigned NCHECK = RAT_NCHECK,
  parameter int unsigned CW     = $clog2(NCHECK)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_req,
  input  logic          rel,
  input  logic          restore_v,
  input  logic [CW-1:0] restore_id,
  input  logic          flush,
  output logic          alloc_ok_c,
  output logic          restore_ok_c,
  output logic [CW-1:0] head,
  output logic          full
);

  logic [CW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW:0]   cnt_q, cnt_d;
  logic [CW-1:0] off;
  logic          rel_ok;

  // Acceptance decisions follow flush > restore > allocate/release priority.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    cnt_d        = cnt_q;
    off          = restore_id - tail_q;
    restore_ok_c = restore_v & ~flush & ~rst & ({1'b0, off} < cnt_q);
    rel_ok       = rel & (cnt_q != '0) & ~flush & ~restore_ok_c;
    alloc_ok_c   = alloc_req & ~flush & ~restore_ok_c & ~rst &
                   ((cnt_q != (CW+1)'(NCHECK)) | rel_ok);
    if (flush) begin
      head_d = tail_q;
      cnt_d  = '0;
    end else if (restore_ok_c) begin
      head_d = restore_id;
      cnt_d  = {1'b0, off};
    end else begin
      if (alloc_ok_c) head_d = head_q + CW'(1);
      if (rel_ok)     tail_d = tail_q + CW'(1);
      cnt_d = cnt_q + (CW+1)'(alloc_ok_c) - (CW+1)'(rel_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head = head_q;
  assign full = (cnt_q == (CW+1)'(NCHECK));

endmodule

// File: rtl/thor2025_rat_ckpt.sv
// Register alias table: speculative and committed maps, checkpoint snapshots, commit-time free list return.
module thor2025_rat_ckpt
  import thor2025_rat_pkg::*;
#(
  parameter int unsigned NAREG  = RAT_NAREG,
  parameter int unsigned NPREG  = RAT_NPREG,
  parameter int unsigned NLANE  = RAT_NLANE,
  parameter int unsigned NRD    = RAT_NRD,
  parameter int unsigned NCHECK = RAT_NCHECK,
  localparam int unsigned AW = $clog2(NAREG),
  localparam int unsigned PW = $clog2(NPREG),
  localparam int unsigned CW = $clog2(NCHECK)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       nq,
  input  logic [NLANE-1:0]           wr,
  input  logic [NLANE-1:0][AW-1:0]   wra,
  input  logic [NLANE-1:0][PW-1:0]   wrp,
  input  logic [NRD-1:0][AW-1:0]     rn,
  output logic [NRD-1:0][PW-1:0]     rrn,
  output logic [NRD-1:0]             vn,
  input  logic                       ckpt_req,
  output logic                       ckpt_ack,
  output logic [CW-1:0]              ckpt_id,
  output logic                       ckpt_full,
  input  logic                       ckpt_rel,
  input  logic                       restore_v,
  input  logic [CW-1:0]              restore_id,
  input  logic                       flush,
  input  logic [NLANE-1:0]           cmtv,
  input  logic [NLANE-1:0][AW-1:0]   cmta,
  input  logic [NLANE-1:0][PW-1:0]   cmtp,
  output logic [NLANE-1:0]           freev,
  output logic [NLANE-1:0][PW-1:0]   freep
);

  rat_entry_t spec_q   [NAREG];
  rat_entry_t cmt_q    [NAREG];
  rat_entry_t ckpt_mem [NCHECK][NAREG];
  rat_entry_t spec_ren [NAREG];
  rat_entry_t spec_d   [NAREG];
  rat_entry_t cmt_d    [NAREG];

  logic [NLANE-1:0]         freev_d;
  logic [NLANE-1:0][PW-1:0] freep_d;
  logic                     restore_ok;
  logic [CW-1:0]            head;

  thor2025_rat_ckpt_q #(
    .NCHECK (NCHECK)
  ) u_q (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (ckpt_req & nq),
    .rel          (ckpt_rel),
    .restore_v    (restore_v),
    .restore_id   (restore_id),
    .flush        (flush),
    .alloc_ok_c   (ckpt_ack),
    .restore_ok_c (restore_ok),
    .head         (head),
    .full         (ckpt_full)
  );

  assign ckpt_id = head;

  // Lookups see only the map as it stood at the start of the cycle.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      if (rn[i] == '0) begin
        rrn[i] = '0;
        vn[i]  = 1'b1;
      end else begin
        rrn[i] = spec_q[rn[i]].preg;
        vn[i]  = spec_q[rn[i]].valid;
      end
    end
  end

  // Lanes are applied in order so later lanes win and chain frees within a group.
  always_comb begin
    freev_d = '0;
    freep_d = '0;
    for (int a = 0; a < NAREG; a++) begin
      cmt_d[a]    = cmt_q[a];
      spec_ren[a] = spec_q[a];
    end
    for (int l = 0; l < NLANE; l++) begin
      if (cmtv[l] && cmta[l] != '0) begin
        freev_d[l]        = 1'b1;
        freep_d[l]        = cmt_d[cmta[l]].preg;
        cmt_d[cmta[l]]    = '{valid: 1'b1, preg: cmtp[l]};
      end
    end
    if (nq) begin
      for (int l = 0; l < NLANE; l++) begin
        if (wr[l] && wra[l] != '0) spec_ren[wra[l]] = '{valid: 1'b1, preg: wrp[l]};
      end
    end
    for (int a = 0; a < NAREG; a++) begin
      if (flush)           spec_d[a] = cmt_d[a];
      else if (restore_ok) spec_d[a] = ckpt_mem[restore_id][a];
      else                 spec_d[a] = spec_ren[a];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned a = 0; a < NAREG; a++) begin
        spec_q[a] <= '{valid: 1'b1, preg: RAT_PW'(a)};
        cmt_q[a]  <= '{valid: 1'b1, preg: RAT_PW'(a)};
      end
      for (int c = 0; c < NCHECK; c++) begin
        for (int a = 0; a < NAREG; a++) ckpt_mem[c][a] <= '0;
      end
      freev <= '0;
      freep <= '0;
    end else begin
      for (int a = 0; a < NAREG; a++) begin
        spec_q[a] <= spec_d[a];
        cmt_q[a]  <= cmt_d[a];
      end
      if (ckpt_ack) begin
        for (int a = 0; a < NAREG; a++) ckpt_mem[head][a] <= spec_ren[a];
      end
      freev <= freev_d;
      freep <= freep_d;
    end
  end

endmodule
